// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU constants: memory access-size encodings and the memory-port owner tag.
// Used by mem_port_arbiter and mem_owner_fifo.
package mem_port_arbiter_pkg;

  localparam logic [1:0] BYTE        = 2'b00;
  localparam logic [1:0] HALF_WORD   = 2'b01;
  localparam logic [1:0] WORD        = 2'b10;
  localparam logic [1:0] DOUBLE_WORD = 2'b11;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } mem_owner_e;

  function automatic mem_owner_e other_owner(input mem_owner_e o);
    return (o == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
  endfunction

endpackage

// File: rtl/mem_owner_fifo.sv
// In-order FIFO of memory-transaction owners; one entry per accepted, unanswered request.
// Synchronous reset to empty. Pushes while full and pops while empty are ignored.
module mem_owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       push,
  input  mem_owner_e push_owner,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output mem_owner_e head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mem_owner_e       mem_q [DEPTH];
  mem_owner_e       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_owner;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= OWNER_INSTR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, routing in-order responses back.
// MEM_ARB_DATA_PRIORITY_EN selects fixed data priority instead of round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_sync,
  input  logic        instr_req_i,
  input  logic [63:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [63:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [63:0] data_addr_i,
  input  logic [1:0]  data_byte_en_i,
  input  logic        data_wr_i,
  input  logic [63:0] data_wr_data_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [63:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  output logic [1:0]  mem_byte_en_o,
  output logic        mem_wr_o,
  output logic [63:0] mem_wr_data_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        err_unexp_rsp_o
);

  // Handshake: a request transfers on a cycle where mem_req_o & mem_gnt_i; once
  // mem_req_o is raised without a grant, the winner is locked and its fields held
  // until granted. Every transfer gets exactly one in-order mem_rvalid_i.

  mem_owner_e winner, head_owner;
  mem_owner_e lock_owner_q, lock_owner_d;
  logic       lock_valid_q, lock_valid_d;
  logic       err_q, err_d;
  logic       fifo_full, fifo_empty, grant, pop;
`ifndef MEM_ARB_DATA_PRIORITY_EN
  mem_owner_e rr_last_q, rr_last_d;
`endif

  always_comb begin
    winner = OWNER_INSTR;
    if (lock_valid_q) begin
      winner = lock_owner_q;
    end else begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
      if (data_req_i) winner = OWNER_DATA;
`else
      if (instr_req_i && data_req_i) winner = other_owner(rr_last_q);
      else if (data_req_i)           winner = OWNER_DATA;
`endif
    end
  end

  // Occupancy is judged before any same-cycle pop, so a full FIFO always stalls.
  assign mem_req_o   = ~reset_sync & (instr_req_i | data_req_i | lock_valid_q) & ~fifo_full;
  assign grant       = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = grant & (winner == OWNER_INSTR);
  assign data_gnt_o  = grant & (winner == OWNER_DATA);

  always_comb begin
    mem_addr_o    = instr_addr_i;
    mem_byte_en_o = WORD;
    mem_wr_o      = 1'b0;
    mem_wr_data_o = '0;
    if (winner == OWNER_DATA) begin
      mem_addr_o    = data_addr_i;
      mem_byte_en_o = data_byte_en_i;
      mem_wr_o      = data_wr_i;
      mem_wr_data_o = data_wr_data_i;
    end
  end

  assign pop            = ~reset_sync & mem_rvalid_i & ~fifo_empty;
  assign instr_rvalid_o = pop & (head_owner == OWNER_INSTR);
  assign data_rvalid_o  = pop & (head_owner == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_unexp_rsp_o = err_q;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    err_d        = err_q | (mem_rvalid_i & fifo_empty);
    if (mem_req_o && !mem_gnt_i) begin
      lock_valid_d = 1'b1;
      lock_owner_d = winner;
    end else if (grant) begin
      lock_valid_d = 1'b0;
    end
  end

`ifndef MEM_ARB_DATA_PRIORITY_EN
  assign rr_last_d = grant ? winner : rr_last_q;

  always_ff @(posedge clk) begin
    if (reset_sync) rr_last_q <= OWNER_DATA;
    else            rr_last_q <= rr_last_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWNER_INSTR;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      err_q        <= err_d;
    end
  end

  mem_owner_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_owner_fifo (
    .clk        (clk),
    .reset_sync (reset_sync),
    .push       (grant),
    .push_owner (winner),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head_owner)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a queue-based reference model checked every cycle.
// Build with MEM_ARB_DATA_PRIORITY_EN to exercise the fixed data-priority variant.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_sync;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [63:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_wr_i, data_gnt_o, data_rvalid_o;
  logic [63:0] data_addr_i, data_wr_data_i, data_rdata_o;
  logic [1:0]  data_byte_en_i, mem_byte_en_o;
  logic        mem_req_o, mem_wr_o, mem_gnt_i, mem_rvalid_i, err_unexp_rsp_o;
  logic [63:0] mem_addr_o, mem_wr_data_o, mem_rdata_i;

  mem_port_arbiter #(.OUTSTANDING_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_sync(reset_sync),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_byte_en_i(data_byte_en_i),
    .data_wr_i(data_wr_i), .data_wr_data_i(data_wr_data_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_unexp_rsp_o(err_unexp_rsp_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoring ----------------
  int checks = 0;
  int passes = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Owners as bits: 0 = instruction fetch, 1 = load/store.
  logic exp_q[$];
  logic m_lock = 1'b0, m_lock_own = 1'b0, m_rr_last = 1'b1, m_err = 1'b0;
  logic e_full, e_empty, e_req, e_win, e_grant, e_pop, e_head;

  always @(negedge clk) begin
    if (reset_sync) begin
      chk1("mdl_rst_req", mem_req_o, 1'b0);
      chk1("mdl_rst_irv", instr_rvalid_o, 1'b0);
      chk1("mdl_rst_drv", data_rvalid_o, 1'b0);
      exp_q.delete();
      m_lock = 1'b0; m_lock_own = 1'b0; m_rr_last = 1'b1; m_err = 1'b0;
    end else begin
      e_full  = (exp_q.size() >= DEPTH);
      e_empty = (exp_q.size() == 0);
      e_head  = e_empty ? 1'b0 : exp_q[0];
      e_req   = (instr_req_i || data_req_i || m_lock) && !e_full;
      if (m_lock)                         e_win = m_lock_own;
`ifdef MEM_ARB_DATA_PRIORITY_EN
      else                                e_win = data_req_i;
`else
      else if (instr_req_i && data_req_i) e_win = !m_rr_last;
      else                                e_win = data_req_i;
`endif
      e_grant = e_req && mem_gnt_i;
      e_pop   = mem_rvalid_i && !e_empty;

      chk1("mdl_req", mem_req_o, e_req);
      chk1("mdl_instr_gnt", instr_gnt_o, e_grant && !e_win);
      chk1("mdl_data_gnt", data_gnt_o, e_grant && e_win);
      if (e_req) begin
        if (e_win) begin
          chk64("mdl_addr", mem_addr_o, data_addr_i);
          chk64("mdl_be", 64'(mem_byte_en_o), 64'(data_byte_en_i));
          chk1("mdl_wr", mem_wr_o, data_wr_i);
          chk64("mdl_wdata", mem_wr_data_o, data_wr_data_i);
        end else begin
          chk64("mdl_addr", mem_addr_o, instr_addr_i);
          chk64("mdl_be", 64'(mem_byte_en_o), 64'(WORD));
          chk1("mdl_wr", mem_wr_o, 1'b0);
          chk64("mdl_wdata", mem_wr_data_o, 64'h0);
        end
      end
      chk1("mdl_instr_rv", instr_rvalid_o, e_pop && !e_head);
      chk1("mdl_data_rv", data_rvalid_o, e_pop && e_head);
      if (e_pop) begin
        chk64("mdl_instr_rdata", instr_rdata_o, mem_rdata_i);
        chk64("mdl_data_rdata", data_rdata_o, mem_rdata_i);
      end
      chk1("mdl_err", err_unexp_rsp_o, m_err);

      if (mem_rvalid_i && e_empty) m_err = 1'b1;
      if (e_pop) void'(exp_q.pop_front());
      if (e_grant) begin
        exp_q.push_back(e_win);
        m_rr_last = e_win;
      end
      if (e_req && !mem_gnt_i) begin
        m_lock = 1'b1; m_lock_own = e_win;
      end else if (e_grant) begin
        m_lock = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic ir, input logic dr, input logic g, input logic rv,
                        input logic [63:0] rd);
    instr_req_i = ir; data_req_i = dr; mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset_sync = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (cycles) next_cycle();
    reset_sync = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    instr_addr_i = 64'h100; data_addr_i = 64'h1000; data_byte_en_i = BYTE;
    data_wr_i = 1'b0; data_wr_data_i = 64'h0;
    reset_sync = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    chk1("rst_mem_req", mem_req_o, 1'b0);
    next_cycle();
    do_reset(2);
    @(negedge clk);
    chk1("post_rst_req", mem_req_o, 1'b0);
    chk1("post_rst_err", err_unexp_rsp_o, 1'b0);
    next_cycle();

    // Both requesters every cycle, response one cycle after each grant.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b1, 1'b1, i > 0, 64'hA0 + 64'(i));
      @(negedge clk);
`ifdef MEM_ARB_DATA_PRIORITY_EN
      chk1("t6_data_gnt", data_gnt_o, 1'b1);
      chk1("t6_instr_gnt", instr_gnt_o, 1'b0);
      chk1("t6_data_rv", data_rvalid_o, i > 0);
`else
      chk1("t1_instr_gnt", instr_gnt_o, (i % 2) == 0);
      chk1("t1_data_gnt", data_gnt_o, (i % 2) == 1);
      chk1("t1_instr_rv", instr_rvalid_o, (i % 2) == 1);
      chk1("t1_data_rv", data_rvalid_o, (i > 0) && ((i % 2) == 0));
`endif
      next_cycle();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 64'hB4);
    @(negedge clk);
    chk1("t1_last_data_rv", data_rvalid_o, 1'b1);
    chk64("t1_last_rdata", data_rdata_o, 64'hB4);
    next_cycle();

    // Locked data request at 0x1000 while instr arrives; grant on the fourth cycle.
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    chk1("t2_req_c1", mem_req_o, 1'b1);
    chk64("t2_addr_c1", mem_addr_o, 64'h1000);
    next_cycle();
    for (int c = 2; c <= 3; c++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk64("t2_addr_locked", mem_addr_o, 64'h1000);
      chk1("t2_instr_gnt_locked", instr_gnt_o, 1'b0);
      next_cycle();
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    @(negedge clk);
    chk1("t2_data_gnt_c4", data_gnt_o, 1'b1);
    chk1("t2_instr_gnt_c4", instr_gnt_o, 1'b0);
    chk64("t2_addr_c4", mem_addr_o, 64'h1000);
    next_cycle();
    @(negedge clk);
`ifdef MEM_ARB_DATA_PRIORITY_EN
    chk1("t2_c5_data_gnt", data_gnt_o, 1'b1);
`else
    chk1("t2_c5_instr_gnt", instr_gnt_o, 1'b1);
    chk64("t2_c5_addr", mem_addr_o, 64'h100);
    chk64("t2_c5_be", 64'(mem_byte_en_o), 64'(2'b10));
`endif
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 64'hC1);
    @(negedge clk);
    chk1("t2_rsp1_data_rv", data_rvalid_o, 1'b1);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 64'hC2);
    @(negedge clk);
`ifdef MEM_ARB_DATA_PRIORITY_EN
    chk1("t2_rsp2_data_rv", data_rvalid_o, 1'b1);
`else
    chk1("t2_rsp2_instr_rv", instr_rvalid_o, 1'b1);
    chk64("t2_rsp2_rdata", instr_rdata_o, 64'hC2);
`endif
    next_cycle();

    // Fill the owner FIFO, then free one slot with a lone response.
    for (int g = 0; g < 2; g++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
      @(negedge clk);
      chk1("t3_fill_gnt", instr_gnt_o, 1'b1);
      next_cycle();
    end
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    @(negedge clk);
    chk1("t3_full_req", mem_req_o, 1'b0);
    chk1("t3_full_gnt", instr_gnt_o, 1'b0);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 64'hD0);
    @(negedge clk);
    chk1("t3_pop_req", mem_req_o, 1'b0);
    chk1("t3_pop_rv", instr_rvalid_o, 1'b1);
    next_cycle();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    @(negedge clk);
    chk1("t3_after_pop_req", mem_req_o, 1'b1);
    chk1("t3_after_pop_gnt", instr_gnt_o, 1'b1);
    next_cycle();
    for (int d = 0; d < 2; d++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 64'hD1 + 64'(d));
      @(negedge clk);
      chk1("t3_drain_rv", instr_rvalid_o, 1'b1);
      next_cycle();
    end

    // Unexpected response with empty FIFO.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD);
    @(negedge clk);
    chk1("t4_instr_rv", instr_rvalid_o, 1'b0);
    chk1("t4_data_rv", data_rvalid_o, 1'b0);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (3) begin
      @(negedge clk);
      chk1("t4_err_sticky", err_unexp_rsp_o, 1'b1);
      next_cycle();
    end

    // Store then ack.
    data_addr_i = 64'h2000; data_wr_i = 1'b1; data_byte_en_i = DOUBLE_WORD;
    data_wr_data_i = 64'h1122334455667788;
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    @(negedge clk);
    chk1("t5_data_gnt", data_gnt_o, 1'b1);
    chk1("t5_mem_wr", mem_wr_o, 1'b1);
    chk64("t5_wdata", mem_wr_data_o, 64'h1122334455667788);
    chk64("t5_be", 64'(mem_byte_en_o), 64'(2'b11));
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    @(negedge clk);
    chk1("t5_data_rv", data_rvalid_o, 1'b1);
    chk1("t5_instr_rv", instr_rvalid_o, 1'b0);
    chk1("t5_err_still", err_unexp_rsp_o, 1'b1);
    next_cycle();
    data_wr_i = 1'b0;

    // Reset clears the sticky error.
    do_reset(1);
    @(negedge clk);
    chk1("rst_clears_err", err_unexp_rsp_o, 1'b0);
    next_cycle();

    // Reset with one transaction in flight discards its owner.
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 64'h0);
    @(negedge clk);
    chk1("mid_gnt", instr_gnt_o, 1'b1);
    next_cycle();
    do_reset(1);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 64'hEE);
    @(negedge clk);
    chk1("mid_stray_rv", instr_rvalid_o, 1'b0);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    chk1("mid_stray_err", err_unexp_rsp_o, 1'b1);
    next_cycle();

    do_reset(1);
    repeat (2) next_cycle();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
